// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width, largest legal digit, a packed
// two-digit type and the binary <-> two-digit BCD conversion helpers.
// The display decoder uses from_bcd2 as well.
package bcd_pkg;

    localparam int unsigned BCD_W   = 4;
    localparam int unsigned BCD2_W  = 2 * BCD_W;
    localparam int unsigned VALUE_W = 7;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef struct packed {
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
    } bcd2_t;

    // Split a binary value 0..99 into tens/ones digits. Only used on
    // constants at elaboration time.
    function automatic bcd2_t to_bcd2(input int unsigned v);
        bcd2_t       r;
        int unsigned t;
        int unsigned o;
        t      = v / 10;
        o      = v % 10;
        r.tens = t[BCD_W-1:0];
        r.ones = o[BCD_W-1:0];
        return r;
    endfunction

    // Combine two digits back into a binary value. Inputs with digits
    // above 9 give a meaningless result; callers reject those first.
    function automatic logic [VALUE_W-1:0] from_bcd2(input bcd2_t b);
        return ({3'b000, b.tens} * 7'd10) + {3'b000, b.ones};
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit stepper. When step is set the digit moves one position
// up or down; it wraps between 0 and lim and flags the wrap on carry,
// which steps the next more significant digit.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic             step,
    input  logic             up,
    input  logic [BCD_W-1:0] cur,
    input  logic [BCD_W-1:0] lim,
    output logic [BCD_W-1:0] nxt,
    output logic             carry
);

    logic at_top;
    logic at_bot;
    logic [BCD_W-1:0] inc_val;
    logic [BCD_W-1:0] dec_val;

    assign at_top  = (cur >= lim);
    assign at_bot  = (cur == '0);
    assign inc_val = at_top ? '0 : cur + 4'd1;
    assign dec_val = at_bot ? lim : cur - 4'd1;

    assign carry = step & (up ? at_top : at_bot);
    assign nxt   = !step ? cur : (up ? inc_val : dec_val);

endmodule

// File: rtl/edge_trigger_D_FF.sv
// Library flip-flop: captures d on the falling clock edge, with
// independent asynchronous active-low clear and preset.
module edge_trigger_D_FF (
    input  logic clk,
    input  logic d,
    input  logic clr_n,
    input  logic pre_n,
    output logic q
);

    // Clear wins over preset; otherwise sample d on the falling edge.
    always_ff @(negedge clk or negedge clr_n or negedge pre_n) begin
        if (!clr_n) begin
            q <= 1'b0;
        end else if (!pre_n) begin
            q <= 1'b1;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo-MOD up/down counter with synchronous load and a
// combinational terminal count for cascading. State lives in eight
// falling-edge library flip-flops.
module bcd_mod_counter
    import bcd_pkg::*;
#(
    parameter int unsigned MOD  = 60,
    parameter int unsigned INIT = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [BCD_W-1:0] load_tens,
    input  logic [BCD_W-1:0] load_ones,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones,
    output logic             tc,
    output logic             zero,
    output logic             load_err
);

    localparam bcd2_t               MAX_BCD   = to_bcd2(MOD - 1);
    localparam bcd2_t               INIT_BCD  = to_bcd2(INIT);
    localparam logic [BCD2_W-1:0]   INIT_BITS = INIT_BCD;
    localparam logic [VALUE_W-1:0]  MAX_VAL   = VALUE_W'(MOD - 1);

    logic [BCD2_W-1:0]  state_q;
    logic [BCD2_W-1:0]  state_d;
    logic [BCD2_W-1:0]  next_val;
    logic [BCD2_W-1:0]  count_val;
    logic [BCD2_W-1:0]  load_val;
    logic [VALUE_W-1:0] value;
    logic [VALUE_W-1:0] load_value;
    logic               at_max;
    logic               at_zero;
    logic               load_ok;
    logic               count_step;
    logic [BCD_W-1:0]   ones_nxt;
    logic [BCD_W-1:0]   tens_nxt;
    logic               ones_carry;
    logic               tens_carry_unused;

    assign tens = state_q[BCD2_W-1:BCD_W];
    assign ones = state_q[BCD_W-1:0];

    assign value   = from_bcd2(state_q);
    assign at_max  = (value == MAX_VAL);
    assign at_zero = (value == '0);

    assign zero = at_zero;
    assign tc   = en & ~load & (up ? at_max : at_zero);

    // A load is only taken when both digits are real BCD and the combined
    // value fits inside the modulus, so codes 10..15 never reach state.
    assign load_val   = {load_tens, load_ones};
    assign load_value = from_bcd2(load_val);
    assign load_ok    = (load_tens <= BCD_MAX) & (load_ones <= BCD_MAX) &
                        (load_value <= MAX_VAL);

    assign count_step = en & ~load;

    bcd_digit u_ones (
        .step  (count_step),
        .up    (up),
        .cur   (ones),
        .lim   (BCD_MAX),
        .nxt   (ones_nxt),
        .carry (ones_carry)
    );

    bcd_digit u_tens (
        .step  (ones_carry),
        .up    (up),
        .cur   (tens),
        .lim   (MAX_BCD.tens),
        .nxt   (tens_nxt),
        .carry (tens_carry_unused)
    );

    // The digit chain handles ordinary BCD rollover; the modulus wrap in
    // either direction is forced here because MOD-1 need not end in 9.
    assign count_val = (up && at_max)   ? '0 :
                       (!up && at_zero) ? MAX_BCD :
                                          {tens_nxt, ones_nxt};

    assign next_val = load ? (load_ok ? load_val : state_q) :
                      en   ? count_val : state_q;

    // While reset is held the flops are also fed the INIT pattern, so the
    // state stays at INIT even if the clock keeps running.
    assign state_d = reset_n ? next_val : INIT_BITS;

    // Each bit clears or presets asynchronously according to its INIT bit.
    for (genvar i = 0; i < BCD2_W; i++) begin : g_state
        edge_trigger_D_FF u_ff (
            .clk   (clk),
            .d     (state_d[i]),
            .clr_n (INIT_BITS[i] ? 1'b1 : reset_n),
            .pre_n (INIT_BITS[i] ? reset_n : 1'b1),
            .q     (state_q[i])
        );
    end

    // Flag a rejected load for the cycle following it.
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_err <= 1'b0;
        end else begin
            load_err <= load & ~load_ok;
        end
    end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Bench for bcd_mod_counter: five instances with different moduli and
// reset values share one stimulus stream; the last one is a minutes
// stage chained from the first one's terminal count.
module tb_bcd_mod_counter;

    localparam int NI = 5;
    localparam int MODS  [NI] = '{60, 100, 60, 7, 60};
    localparam int INITS [NI] = '{0, 0, 30, 5, 0};

    logic       clk;
    logic       reset_n;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_tens;
    logic [3:0] load_ones;

    logic [3:0] tens_o     [NI];
    logic [3:0] ones_o     [NI];
    logic       tc_o       [NI];
    logic       zero_o     [NI];
    logic       load_err_o [NI];

    int mv   [NI];
    bit merr [NI];

    int checks = 0;
    int errors = 0;

    bcd_mod_counter #(.MOD(60), .INIT(0)) u_sec (
        .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load),
        .load_tens(load_tens), .load_ones(load_ones),
        .tens(tens_o[0]), .ones(ones_o[0]), .tc(tc_o[0]),
        .zero(zero_o[0]), .load_err(load_err_o[0])
    );

    bcd_mod_counter #(.MOD(100), .INIT(0)) u_hund (
        .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load),
        .load_tens(load_tens), .load_ones(load_ones),
        .tens(tens_o[1]), .ones(ones_o[1]), .tc(tc_o[1]),
        .zero(zero_o[1]), .load_err(load_err_o[1])
    );

    bcd_mod_counter #(.MOD(60), .INIT(30)) u_init30 (
        .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load),
        .load_tens(load_tens), .load_ones(load_ones),
        .tens(tens_o[2]), .ones(ones_o[2]), .tc(tc_o[2]),
        .zero(zero_o[2]), .load_err(load_err_o[2])
    );

    bcd_mod_counter #(.MOD(7), .INIT(5)) u_mod7 (
        .clk(clk), .reset_n(reset_n), .en(en), .up(up), .load(load),
        .load_tens(load_tens), .load_ones(load_ones),
        .tens(tens_o[3]), .ones(ones_o[3]), .tc(tc_o[3]),
        .zero(zero_o[3]), .load_err(load_err_o[3])
    );

    bcd_mod_counter #(.MOD(60), .INIT(0)) u_min (
        .clk(clk), .reset_n(reset_n), .en(tc_o[0]), .up(up), .load(load),
        .load_tens(load_tens), .load_ones(load_ones),
        .tens(tens_o[4]), .ones(ones_o[4]), .tc(tc_o[4]),
        .zero(zero_o[4]), .load_err(load_err_o[4])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value with the expected one and count it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic bit load_legal(int k);
        int lt;
        int lo;
        lt = int'(load_tens);
        lo = int'(load_ones);
        return (lt <= 9) && (lo <= 9) && (lt * 10 + lo < MODS[k]);
    endfunction

    // Terminal count of instance k given its enable.
    function automatic bit model_tc(int k, bit e);
        if (!e || load) return 1'b0;
        return up ? (mv[k] == MODS[k] - 1) : (mv[k] == 0);
    endfunction

    function automatic bit model_en(int k);
        return (k == NI - 1) ? model_tc(0, en) : en;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            mv[k]   = INITS[k];
            merr[k] = 1'b0;
        end
    endtask

    // Advance the reference by one falling edge.
    task automatic update_model();
        bit ek [NI];
        for (int k = 0; k < NI; k++) ek[k] = model_en(k);
        if (!reset_n) begin
            model_reset();
        end else begin
            for (int k = 0; k < NI; k++) begin
                if (load) begin
                    if (load_legal(k)) begin
                        mv[k]   = int'(load_tens) * 10 + int'(load_ones);
                        merr[k] = 1'b0;
                    end else begin
                        merr[k] = 1'b1;
                    end
                end else begin
                    merr[k] = 1'b0;
                    if (ek[k]) begin
                        if (up) mv[k] = (mv[k] + 1) % MODS[k];
                        else    mv[k] = (mv[k] + MODS[k] - 1) % MODS[k];
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            checkOutput($sformatf("i%0d tens", k), {28'd0, tens_o[k]}, mv[k] / 10);
            checkOutput($sformatf("i%0d ones", k), {28'd0, ones_o[k]}, mv[k] % 10);
            checkOutput($sformatf("i%0d zero", k), {31'd0, zero_o[k]}, {31'd0, mv[k] == 0});
            checkOutput($sformatf("i%0d tc", k), {31'd0, tc_o[k]}, {31'd0, model_tc(k, model_en(k))});
            checkOutput($sformatf("i%0d load_err", k), {31'd0, load_err_o[k]}, {31'd0, merr[k]});
        end
    endtask

    // Drive one cycle of inputs after the rising edge, check every output
    // mid-cycle, then let the reference follow the falling edge.
    task automatic applyStimulus(input bit rst, input bit e, input bit u, input bit l,
                                 input logic [3:0] lt, input logic [3:0] lo);
        @(posedge clk);
        #1;
        reset_n   = rst;
        en        = e;
        up        = u;
        load      = l;
        load_tens = lt;
        load_ones = lo;
        if (!rst) model_reset();
        #1;
        check_all();
        @(negedge clk);
        update_model();
    endtask

    initial begin
        reset_n   = 1'b1;
        en        = 1'b0;
        up        = 1'b1;
        load      = 1'b0;
        load_tens = 4'd0;
        load_ones = 4'd0;
        model_reset();

        // reset state, held across edges
        applyStimulus(0, 0, 1, 0, 4'd0, 4'd0);
        applyStimulus(0, 1, 1, 0, 4'd0, 4'd0);

        // full count-up lap plus wrap; minutes stage steps on the wrap
        for (int i = 0; i < 62; i++) applyStimulus(1, 1, 1, 0, 4'd0, 4'd0);

        // count down through zero
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 1'b0, 0, 4'd0, 4'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 1'b0, 0, 4'd0, 4'd0);

        // load with enable asserted, then illegal loads
        applyStimulus(1, 1, 1, 1, 4'd4, 4'd2);
        applyStimulus(1, 0, 1, 0, 4'd0, 4'd0);
        applyStimulus(1, 1, 1, 1, 4'd6, 4'd0);
        applyStimulus(1, 0, 1, 0, 4'd0, 4'd0);
        applyStimulus(1, 1, 0, 1, 4'd1, 4'hA);
        applyStimulus(1, 0, 1, 0, 4'd0, 4'd0);

        // 59:59 cascade wrap
        applyStimulus(1, 0, 1, 1, 4'd5, 4'd9);
        applyStimulus(1, 1, 1, 0, 4'd0, 4'd0);
        applyStimulus(1, 1, 1, 0, 4'd0, 4'd0);

        // down wrap at 00 for the cascade and MOD=100
        applyStimulus(1, 0, 0, 1, 4'd0, 4'd0);
        applyStimulus(1, 1, 0, 0, 4'd0, 4'd0);
        applyStimulus(1, 1, 0, 0, 4'd0, 4'd0);

        // top end of the hundred-count instance
        applyStimulus(1, 0, 1, 1, 4'd9, 4'd9);
        applyStimulus(1, 1, 1, 0, 4'd0, 4'd0);
        applyStimulus(1, 1, 1, 0, 4'd0, 4'd0);

        // enable toggling every cycle
        for (int i = 0; i < 20; i++) applyStimulus(1, 1'(i % 2), 1, 0, 4'd0, 4'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 7) == 0),
                          4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)));
        end

        // reset between edges mid-count, hold over an edge, then resume
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 0, 4'd0, 4'd0);
        applyStimulus(0, 1, 1, 0, 4'd0, 4'd0);
        applyStimulus(0, 1, 1, 0, 4'd0, 4'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 1, 0, 4'd0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
